// File: rtl/id_stage_param.sv
// Decode stage: bubble insertion, field decode, 8-entry register file with write-through
// bypass and a bounded return-address stack with sticky overflow/underflow flag.
module id_stage_param #(
   parameter int          DW        = 8,
   parameter int          SW        = 12,
   parameter int          SDEPTH    = 8,
   parameter bit          R0_ZERO   = 1'b0,
   parameter logic [18:0] NOP_INSTR = {6'b111101, 13'd0},
   localparam int         CW        = $clog2(SDEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [18:0]   instr_i,
   input  logic          instr_valid_i,
   input  logic          hz_stall_i,
   input  logic          ctrl_stall_i,
   input  logic          r2_sel_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [SW-1:0] stack_in_i,
   input  logic          wr_en_i,
   input  logic [2:0]    wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   output logic [18:0]   ctrl_instr_o,
   output logic          bubble_o,
   output logic [2:0]    r1_addr_o,
   output logic [2:0]    r2_addr_o,
   output logic [2:0]    dest_o,
   output logic [2:0]    shamt_o,
   output logic [7:0]    imm_o,
   output logic [DW-1:0] rd1_o,
   output logic [DW-1:0] rd2_o,
   output logic [SW-1:0] stack_top_o,
   output logic [CW-1:0] stack_count_o,
   output logic          stack_full_o,
   output logic          stack_empty_o,
   output logic          stack_err_o
);

   localparam int AW = $clog2(SDEPTH);

   logic          stall_q;
   logic [DW-1:0] rf_q [8];
   logic [SW-1:0] stk_q [SDEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          epush, epop;
   logic          stk_we;
   logic [AW-1:0] stk_widx;
   logic [AW-1:0] top_idx;

   // Controller stall takes effect one cycle after it is requested.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= ctrl_stall_i;
      end
   end

   assign bubble_o     = hz_stall_i | stall_q | ~instr_valid_i;
   assign ctrl_instr_o = bubble_o ? NOP_INSTR : instr_i;

   assign dest_o    = instr_i[13:11];
   assign r1_addr_o = instr_i[10:8];
   assign shamt_o   = instr_i[7:5];
   assign imm_o     = instr_i[7:0];
   assign r2_addr_o = r2_sel_i ? instr_i[13:11] : instr_i[7:5];

   // Register writes come from writeback and are deliberately not gated by bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wr_en_i && !(R0_ZERO && wr_addr_i == 3'd0)) begin
         rf_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_comb begin
      rd1_o = rf_q[r1_addr_o];
      if (wr_en_i && wr_addr_i == r1_addr_o) begin
         rd1_o = wr_data_i;
      end
      if (R0_ZERO && r1_addr_o == 3'd0) begin
         rd1_o = '0;
      end
   end

   always_comb begin
      rd2_o = rf_q[r2_addr_o];
      if (wr_en_i && wr_addr_i == r2_addr_o) begin
         rd2_o = wr_data_i;
      end
      if (R0_ZERO && r2_addr_o == 3'd0) begin
         rd2_o = '0;
      end
   end

   assign epush = push_i & ~bubble_o;
   assign epop  = pop_i & ~bubble_o;

   // Push+pop on a non-empty stack replaces the top; on an empty stack it is a plain push.
   always_comb begin
      cnt_d    = cnt_q;
      err_d    = err_q;
      stk_we   = 1'b0;
      stk_widx = '0;
      if (epush && epop && cnt_q != '0) begin
         stk_we   = 1'b1;
         stk_widx = AW'(cnt_q - CW'(1));
      end else if (epush) begin
         if (cnt_q < CW'(SDEPTH)) begin
            stk_we   = 1'b1;
            stk_widx = AW'(cnt_q);
            cnt_d    = cnt_q + CW'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (epop) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < SDEPTH; i++) begin
            stk_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
         if (stk_we) begin
            stk_q[stk_widx] <= stack_in_i;
         end
      end
   end

   assign top_idx       = AW'(cnt_q - CW'(1));
   assign stack_top_o   = (cnt_q != '0) ? stk_q[top_idx] : '0;
   assign stack_count_o = cnt_q;
   assign stack_empty_o = (cnt_q == '0);
   assign stack_full_o  = (cnt_q == CW'(SDEPTH));
   assign stack_err_o   = err_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: two instances (R0_ZERO=0 and 1) share stimulus;
// expected values are queued per step and compared once outputs have settled.
module tb_id_stage_param;

   localparam int          DW     = 8;
   localparam int          SW     = 12;
   localparam int          SDEPTH = 8;
   localparam int          CW     = $clog2(SDEPTH + 1);
   localparam logic [18:0] NOP    = {6'b111101, 13'd0};

   logic          clk = 1'b0;
   logic          rst;
   logic [18:0]   instr;
   logic          instr_valid, hz_stall, ctrl_stall, r2_sel, push, pop, wr_en;
   logic [SW-1:0] stack_in;
   logic [2:0]    wr_addr;
   logic [DW-1:0] wr_data;

   logic [18:0]   ci0, ci1;
   logic          bub0, bub1;
   logic [2:0]    r1a0, r2a0, dst0, sh0, r1a1, r2a1, dst1, sh1;
   logic [7:0]    imm0, imm1;
   logic [DW-1:0] rd1_0, rd2_0, rd1_1, rd2_1;
   logic [SW-1:0] top0, top1;
   logic [CW-1:0] cnt0, cnt1;
   logic          full0, emp0, err0, full1, emp1, err1;

   always #5 clk = ~clk;

   id_stage_param #(.R0_ZERO(1'b0)) u0 (
      .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
      .hz_stall_i(hz_stall), .ctrl_stall_i(ctrl_stall), .r2_sel_i(r2_sel),
      .push_i(push), .pop_i(pop), .stack_in_i(stack_in),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .ctrl_instr_o(ci0), .bubble_o(bub0), .r1_addr_o(r1a0), .r2_addr_o(r2a0),
      .dest_o(dst0), .shamt_o(sh0), .imm_o(imm0), .rd1_o(rd1_0), .rd2_o(rd2_0),
      .stack_top_o(top0), .stack_count_o(cnt0), .stack_full_o(full0),
      .stack_empty_o(emp0), .stack_err_o(err0)
   );

   id_stage_param #(.R0_ZERO(1'b1)) u1 (
      .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
      .hz_stall_i(hz_stall), .ctrl_stall_i(ctrl_stall), .r2_sel_i(r2_sel),
      .push_i(push), .pop_i(pop), .stack_in_i(stack_in),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .ctrl_instr_o(ci1), .bubble_o(bub1), .r1_addr_o(r1a1), .r2_addr_o(r2a1),
      .dest_o(dst1), .shamt_o(sh1), .imm_o(imm1), .rd1_o(rd1_1), .rd2_o(rd2_1),
      .stack_top_o(top1), .stack_count_o(cnt1), .stack_full_o(full1),
      .stack_empty_o(emp1), .stack_err_o(err1)
   );

   typedef enum int {
      S_BUB, S_CI, S_DST, S_R1, S_R2, S_SH, S_IMM, S_RD1, S_RD2, S_RD1Z, S_RD2Z,
      S_TOP, S_CNT, S_FULL, S_EMP, S_ERR, S_CI1, S_CNT1, S_ERR1
   } sig_e;

   typedef struct {
      string       tag;
      sig_e        sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [31:0] obs(input sig_e s);
      case (s)
         S_BUB:  return 32'(bub0);
         S_CI:   return 32'(ci0);
         S_DST:  return 32'(dst0);
         S_R1:   return 32'(r1a0);
         S_R2:   return 32'(r2a0);
         S_SH:   return 32'(sh0);
         S_IMM:  return 32'(imm0);
         S_RD1:  return 32'(rd1_0);
         S_RD2:  return 32'(rd2_0);
         S_RD1Z: return 32'(rd1_1);
         S_RD2Z: return 32'(rd2_1);
         S_TOP:  return 32'(top0);
         S_CNT:  return 32'(cnt0);
         S_FULL: return 32'(full0);
         S_EMP:  return 32'(emp0);
         S_ERR:  return 32'(err0);
         S_CI1:  return 32'(ci1);
         S_CNT1: return 32'(cnt1);
         S_ERR1: return 32'(err1);
         default: return 'x;
      endcase
   endfunction

   task automatic ex(input string tag, input sig_e s, input logic [31:0] v);
      sb.push_back('{tag, s, v});
   endtask

   task automatic exp_stk(input string tag, input int cnt, input int top, input int err);
      ex({tag, "_cnt"},   S_CNT,  32'(cnt));
      ex({tag, "_top"},   S_TOP,  32'(top));
      ex({tag, "_full"},  S_FULL, 32'(cnt == SDEPTH));
      ex({tag, "_empty"}, S_EMP,  32'(cnt == 0));
      ex({tag, "_err"},   S_ERR,  32'(err));
   endtask

   task automatic chk();
      exp_t        e;
      logic [31:0] o;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.sig);
         n_total++;
         assert (o === e.val) n_pass++;
         else $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end of the sequence");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; instr = '0; instr_valid = 1'b0; hz_stall = 1'b0; ctrl_stall = 1'b0;
      r2_sel = 1'b0; push = 1'b0; pop = 1'b0; stack_in = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      #2;
      ex("rst_bubble", S_BUB, 1); ex("rst_ci", S_CI, NOP);
      ex("rst_rd1", S_RD1, 0); ex("rst_rd2", S_RD2, 0);
      exp_stk("rst", 0, 0, 0);
      chk();

      // decode and bubble behaviour
      @(negedge clk); rst = 1'b0; instr = 19'h1ABCD; instr_valid = 1'b1;
      ex("dec_bubble", S_BUB, 0); ex("dec_ci", S_CI, 19'h1ABCD);
      ex("dec_dest", S_DST, 5); ex("dec_r1", S_R1, 3); ex("dec_r2_sel0", S_R2, 6);
      ex("dec_shamt", S_SH, 6); ex("dec_imm", S_IMM, 8'hCD);
      chk();
      @(negedge clk); ctrl_stall = 1'b1; r2_sel = 1'b1;
      ex("cs_req_bubble", S_BUB, 0); ex("cs_req_ci", S_CI, 19'h1ABCD);
      ex("dec_r2_sel1", S_R2, 5);
      chk();
      @(negedge clk); ctrl_stall = 1'b0;
      ex("cs_late_bubble", S_BUB, 1); ex("cs_late_ci", S_CI, NOP); ex("cs_late_ci_r0z", S_CI1, NOP);
      chk();
      @(negedge clk);
      ex("cs_after_bubble", S_BUB, 0); ex("cs_after_ci", S_CI, 19'h1ABCD);
      chk();
      @(negedge clk); hz_stall = 1'b1;
      ex("hz_bubble", S_BUB, 1); ex("hz_ci", S_CI, NOP);
      chk();
      @(negedge clk); hz_stall = 1'b0; instr_valid = 1'b0;
      ex("inv_bubble", S_BUB, 1); ex("inv_ci", S_CI, NOP);
      chk();

      // register file and bypass
      @(negedge clk); instr_valid = 1'b1; r2_sel = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;
      ex("byp_rd1", S_RD1, 8'h5A); ex("byp_rd1_r0z", S_RD1Z, 8'h5A); ex("byp_rd2", S_RD2, 0);
      chk();
      @(negedge clk); wr_en = 1'b0;
      ex("reg_rd1", S_RD1, 8'h5A); ex("reg_rd1_r0z", S_RD1Z, 8'h5A);
      chk();
      @(negedge clk); instr = 19'h000E0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
      ex("r0_byp", S_RD1, 8'hFF); ex("r0_byp_r0z", S_RD1Z, 0);
      chk();
      @(negedge clk); instr_valid = 1'b0; wr_addr = 3'd7; wr_data = 8'h3C;
      ex("r0_reg", S_RD1, 8'hFF); ex("r0_reg_r0z", S_RD1Z, 0);
      ex("r7_byp", S_RD2, 8'h3C); ex("r7_byp_r0z", S_RD2Z, 8'h3C); ex("wr_bub", S_BUB, 1);
      chk();
      @(negedge clk); wr_en = 1'b0; instr_valid = 1'b1; instr = 19'h018E0; r2_sel = 1'b1;
      ex("rd2_dest_addr", S_RD2, 8'h5A); ex("rd2_dest_addr_r0z", S_RD2Z, 8'h5A);
      ex("r0_hold_r0z", S_RD1Z, 0);
      chk();
      @(negedge clk); r2_sel = 1'b0;
      ex("r7_under_bubble", S_RD2, 8'h3C); ex("r7_under_bubble_r0z", S_RD2Z, 8'h3C);
      chk();

      // fill the stack, then overflow once
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk); push = 1'b1; stack_in = SW'(i);
         exp_stk("fill", i - 1, i - 1, 0);
         chk();
      end
      @(negedge clk); push = 1'b0; pop = 1'b1; r2_sel = 1'b1;
      exp_stk("ovf", 8, 8, 1);
      chk();
      for (int i = 7; i >= 6; i--) begin
         @(negedge clk);
         exp_stk("pop", i, i, 1);
         chk();
      end
      @(negedge clk); pop = 1'b0;
      exp_stk("pop5", 5, 5, 1);
      ex("pre_arst_rd1", S_RD1, 8'hFF); ex("pre_arst_rd2", S_RD2, 8'h5A);
      chk();

      // asynchronous reset between clock edges
      #1 rst = 1'b1;
      exp_stk("arst", 0, 0, 0);
      ex("arst_rd1", S_RD1, 0); ex("arst_rd2", S_RD2, 0);
      ex("arst_rd1_r0z", S_RD1Z, 0); ex("arst_rd2_r0z", S_RD2Z, 0);
      ex("arst_cnt_r0z", S_CNT1, 0); ex("arst_err_r0z", S_ERR1, 0);
      chk();
      rst = 1'b0;

      // stalled push is dropped; pop on empty flags an error
      @(negedge clk); hz_stall = 1'b1; push = 1'b1; stack_in = 12'h0EE;
      @(negedge clk); hz_stall = 1'b0; push = 1'b0;
      exp_stk("hz_push", 0, 0, 0);
      chk();
      @(negedge clk); pop = 1'b1;
      @(negedge clk); pop = 1'b0;
      exp_stk("udf", 0, 0, 1);
      chk();

      // push+pop replaces top, or pushes when empty
      @(negedge clk); push = 1'b1; stack_in = 12'h090;
      @(negedge clk); stack_in = 12'h0A0;
      @(negedge clk); pop = 1'b1; stack_in = 12'h0B0;
      exp_stk("pp_pre", 2, 12'h0A0, 1);
      chk();
      @(negedge clk); push = 1'b0;
      exp_stk("pp_repl", 2, 12'h0B0, 1);
      chk();
      @(negedge clk);
      exp_stk("pp_below", 1, 12'h090, 1);
      chk();
      @(negedge clk); push = 1'b1; stack_in = 12'h0B0;
      exp_stk("pp_empty_pre", 0, 0, 1);
      chk();
      @(negedge clk); push = 1'b0; pop = 1'b0;
      exp_stk("pp_empty", 1, 12'h0B0, 1);
      chk();

      // reset held across an edge discards that cycle's write and push
      @(negedge clk); rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h99;
      push = 1'b1; instr = 19'h00400; r2_sel = 1'b0;
      @(negedge clk); rst = 1'b0; wr_en = 1'b0; push = 1'b0;
      ex("rstw_rd1", S_RD1, 0); ex("rstw_rd1_r0z", S_RD1Z, 0);
      exp_stk("rstw", 0, 0, 0);
      chk();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
